// File: rtl/mux_arb_nx1.sv
// N-to-1 channel multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output stage with valid/ready handshakes.
module mux_arb_nx1 #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  logic [SEL_W-1:0]    ptr_r;
  logic                load_ok_s;
  logic                found_s;
  logic [SEL_W-1:0]    grant_idx_s;
  logic [SEL_W-1:0]    cand_s;
  logic [CHANNELS-1:0] grant_s;

  function automatic logic [WIDTH-1:0] pick_word(
    input logic [CHANNELS*WIDTH-1:0] bus,
    input logic [SEL_W-1:0]          idx
  );
    pick_word = bus[idx*WIDTH +: WIDTH];
  endfunction

  assign load_ok_s = ~out_valid | out_ready;

  // Grant selection: fixed index in mode 0, rotating search after ptr in mode 1.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    grant_s     = '0;
    if (rst || !load_ok_s) begin
      found_s = 1'b0;
    end else if (mode == 1'b0) begin
      if (in_valid[sel]) begin
        found_s     = 1'b1;
        grant_idx_s = sel;
      end else begin
        found_s = 1'b0;
      end
    end else begin
      for (int i = 1; i <= CHANNELS; i++) begin
        cand_s = ptr_r + SEL_W'(i);
        if (!found_s && in_valid[cand_s]) begin
          found_s     = 1'b1;
          grant_idx_s = cand_s;
        end else begin
          found_s = found_s;
        end
      end
    end
    if (found_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign in_ready = grant_s;

  // Output register and last-grant pointer; reset parks ptr so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr_r     <= {SEL_W{1'b1}};
    end else if (found_s) begin
      out       <= pick_word(in_data, grant_idx_s);
      out_sel   <= grant_idx_s;
      out_valid <= 1'b1;
      ptr_r     <= grant_idx_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed self-checking bench for mux_arb_nx1 (WIDTH=4, CHANNELS=4).
module tb_mux_arb_nx1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  mux_arb_nx1 #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_data   = {4'h3, 4'h2, 4'h1, 4'h0};
    in_valid  = 4'hF;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #5;
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_sel", 32'(out_sel), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    #6 rst = 1'b0;
    #1 check("rr_first_ready", 32'(in_ready), 32'h1);

    // round-robin streaming from reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_out", 32'(out), 32'(i % 4));
      check("rr_out_sel", 32'(out_sel), 32'(i % 4));
      check("rr_valid", 32'(out_valid), 32'h1);
      check("rr_ready", 32'(in_ready), 32'h1 << ((i + 1) % 4));
    end

    // backpressure for 3 cycles
    out_ready = 1'b0;
    #1 check("bp_ready0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_out", 32'(out), 32'h0);
      check("bp_out_sel", 32'(out_sel), 32'h0);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 32'h2);
    tick();
    check("bp_resume1", 32'(out), 32'h1);
    tick();
    check("bp_resume2", 32'(out), 32'h2);
    check("bp_resume2_ready", 32'(in_ready), 32'h8);

    // sparse valid 1010
    in_valid = 4'b1010;
    #1 check("sp_ready0", 32'(in_ready), 32'h8);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("sp_out", 32'(out), (j % 2 == 1) ? 32'h1 : 32'h3);
      check("sp_ready", 32'(in_ready), (j % 2 == 1) ? 32'h8 : 32'h2);
      check("sp_no_even", 32'(in_ready & 4'b0101), 32'h0);
    end

    // all-invalid drain
    in_valid = 4'h0;
    #1 check("drain_ready", 32'(in_ready), 32'h0);
    tick();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_out", 32'(out), 32'h1);
    check("drain_out_sel", 32'(out_sel), 32'h1);
    tick();
    check("drain_valid2", 32'(out_valid), 32'h0);
    check("drain_out2", 32'(out), 32'h1);

    // fixed select stepping
    mode     = 1'b0;
    in_valid = 4'hF;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1 check("fx_ready", 32'(in_ready), 32'h1 << s);
      for (int c = 0; c < 10; c++) begin
        tick();
        check("fx_out", 32'(out), 32'(s));
        check("fx_out_sel", 32'(out_sel), 32'(s));
        check("fx_valid", 32'(out_valid), 32'h1);
      end
    end
    sel = 2'd1;
    tick();
    check("fx_sel1", 32'(out), 32'h1);
    mode = 1'b1;
    #1 check("ptr_from_mode0", 32'(in_ready), 32'h4);

    // fixed select of an invalid channel
    mode     = 1'b0;
    in_valid = 4'b1101;
    #1 check("fx_invalid_ready", 32'(in_ready), 32'h0);
    tick();
    check("fx_invalid_valid", 32'(out_valid), 32'h0);
    check("fx_invalid_out", 32'(out), 32'h1);

    // async reset mid-stream
    mode     = 1'b1;
    in_valid = 4'hF;
    #1 check("ar_ready", 32'(in_ready), 32'h4);
    tick();
    check("ar_out2", 32'(out), 32'h2);
    check("ar_valid", 32'(out_valid), 32'h1);
    tick();
    check("ar_out3", 32'(out), 32'h3);
    #3 rst = 1'b1;
    #1;
    check("ar_rst_out", 32'(out), 32'h0);
    check("ar_rst_valid", 32'(out_valid), 32'h0);
    check("ar_rst_sel", 32'(out_sel), 32'h0);
    check("ar_rst_ready", 32'(in_ready), 32'h0);
    #1 rst = 1'b0;
    #1 check("ar_post_ready", 32'(in_ready), 32'h1);
    tick();
    check("ar_post_out", 32'(out), 32'h0);
    check("ar_post_sel", 32'(out_sel), 32'h0);
    check("ar_post_valid", 32'(out_valid), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_arb_nx1.md
MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
REQ-001 Parameter WIDTH, default 4, data width per channel in bits (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (power of two, >=2); SEL_W = log2(CHANNELS).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 in_valid  input  CHANNELS  per-channel data-valid.
REQ-007 in_ready  output  CHANNELS  per-channel accept strobe; at most one bit high per cycle.
REQ-008 mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration.
REQ-009 sel  input  SEL_W  channel index used when mode=0.
REQ-010 out  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  out holds a valid word.
REQ-012 out_ready  input  1  downstream accepts out this cycle.
REQ-013 out_sel  output  SEL_W  index of the channel that supplied out.

Function
REQ-014 Single output register stage; transfer on a channel k occurs in a cycle where in_valid[k] and in_ready[k] are both 1.
REQ-015 Register may load ("load_ok") when out_valid=0 or out_ready=1 in the same cycle.
REQ-016 Mode 0: grant channel sel iff load_ok and in_valid[sel]; otherwise no grant; other channels never granted.
REQ-017 Mode 1: grant, when load_ok, the first channel with in_valid=1 searching ptr+1, ptr+2, ... modulo CHANNELS, where ptr is the last granted channel index.
REQ-018 ptr updates to the granted index on every grant, in both modes; ptr is unchanged when no grant.
REQ-019 in_ready is combinational from in_valid, mode, sel, ptr, out_valid, out_ready; in_ready[k]=1 only for the granted channel.
REQ-020 On grant of channel k: next cycle out = in_data[k], out_sel = k, out_valid = 1 (latency 1 cycle).
REQ-021 out_valid=1 and out_ready=1 with no grant: out_valid falls to 0 next cycle; out and out_sel hold last values.
REQ-022 out_valid=1 and out_ready=0: out, out_sel, out_valid hold; in_ready all zero (backpressure).
REQ-023 Simultaneous drain and grant (out_ready=1, grant present): new word loaded, out_valid stays 1, full throughput of one word per cycle.
REQ-024 Mode or sel changes take effect in the same cycle for arbitration; a word already in the output register is unaffected.
REQ-025 ptr wrap-around: after granting CHANNELS-1, search starts at channel 0.
REQ-026 All-invalid inputs: no grant, in_ready = 0, ptr holds.
REQ-027 out is never X after reset; no output changes except on rising clk or rst assertion.

Reset
REQ-028 rst=1 immediately forces out=0, out_sel=0, out_valid=0, ptr=CHANNELS-1 (first round-robin search starts at channel 0).
REQ-029 While rst=1, in_ready = 0 on all channels; no transfer occurs.
REQ-030 rst asserted mid-transfer discards the held word; first grant after release follows REQ-016/REQ-017 from reset state.

Verification (WIDTH=4, CHANNELS=4, in_data channels 0..3 = 0x0,0x1,0x2,0x3)
REQ-031 Mode 0, all in_valid=1, out_ready=1, sel stepped 0,1,2,3 every 10 cycles -> out equals sel value one cycle after each change, out_sel=sel, out_valid stays 1.
REQ-032 Mode 1, all in_valid=1, out_ready=1 from reset -> out sequence 0x0,0x1,0x2,0x3,0x0,... one per cycle, in_ready one-hot rotating.
REQ-033 Mode 1, in_valid=4'b1010 -> out alternates 0x1,0x3; channels 0 and 2 never granted.
REQ-034 Mode 1 streaming, out_ready held 0 for 3 cycles -> out/out_sel frozen, in_ready=0 throughout; on release sequence resumes with next channel, no word lost or duplicated.
REQ-035 Async reset asserted between clock edges while out_valid=1 -> out=0, out_valid=0 before the next edge; after release first mode-1 grant is channel 0.
REQ-036 in_valid=0 on all channels with out_ready=1 after one word -> out_valid drops to 0 next cycle, out holds last value.
